// File: rtl/alarm_snooze_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_snooze_ctrl
//  Description : Alarm ring / snooze sequencer. Starts ringing when the
//                time reaches the alarm setting at second zero. Rings for a
//                bounded number of seconds, and allows a limited number of
//                snoozes per alarm event.
//  Ports       : clk, rst (async, active-low)
//                tick            - one-cycle once-per-second strobe
//                tsec/tmin/thrs  - current time (binary, 7 bits each)
//                amin/ahrs       - alarm setting (binary, 7 bits each)
//                alarmon         - alarm enable level
//                snooze          - snooze button level (synchronous to clk)
//                buzz            - sound request (state == RING)
//                snoozing        - snooze interval running (state == SNOOZE)
//                snz_used        - snoozes consumed in the current event
//  Revision    : 1.0 - initial release
// ============================================================================
module alarm_snooze_ctrl #(
    parameter int SNOOZE_MIN = 9,   // snooze length in minutes, 1..60
    parameter int RING_SEC   = 60,  // auto-silence timeout in seconds, 1..255
    parameter int MAX_SNOOZE = 3    // snoozes per alarm event, 0..3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [6:0] tsec,
    input  logic [6:0] tmin,
    input  logic [6:0] thrs,
    input  logic [6:0] amin,
    input  logic [6:0] ahrs,
    input  logic       alarmon,
    input  logic       snooze,
    output logic       buzz,
    output logic       snoozing,
    output logic [1:0] snz_used
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RING   = 2'd1,
        S_SNOOZE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [11:0] c_snz_load  = 12'(SNOOZE_MIN * 60);
    localparam logic [7:0]  c_ring_last = 8'(RING_SEC - 1);
    localparam logic [1:0]  c_max_snz   = 2'(MAX_SNOOZE);

    state_t      r_state;
    logic [7:0]  r_ring_cnt;
    logic [11:0] r_snz_tmr;
    logic [1:0]  r_snz_used;
    logic        r_snooze_q;

    state_t      w_state_nxt;
    logic [7:0]  w_ring_nxt;
    logic [11:0] w_tmr_nxt;
    logic [1:0]  w_used_nxt;

    logic        w_match;
    logic        w_snz_edge;
    logic        w_trigger;

    assign w_match    = (tmin == amin) && (thrs == ahrs);
    assign w_snz_edge = snooze && !r_snooze_q;
    assign w_trigger  = tick && (tsec == 7'd0) && w_match;

    // ------------------------------------------------------------------
    // State and counter registers. r_snooze_q resets high so that a button
    // held through reset release is not seen as a fresh press.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_ring_cnt <= '0;
            r_snz_tmr  <= '0;
            r_snz_used <= '0;
            r_snooze_q <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_ring_cnt <= w_ring_nxt;
            r_snz_tmr  <= w_tmr_nxt;
            r_snz_used <= w_used_nxt;
            r_snooze_q <= snooze;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Disabling the alarm overrides everything; every
    // path into IDLE clears the per-event bookkeeping.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_ring_nxt  = r_ring_cnt;
        w_tmr_nxt   = r_snz_tmr;
        w_used_nxt  = r_snz_used;

        if (!alarmon) begin
            w_state_nxt = S_IDLE;
            w_ring_nxt  = '0;
            w_tmr_nxt   = '0;
            w_used_nxt  = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_trigger) begin
                        w_state_nxt = S_RING;
                        w_ring_nxt  = '0;
                    end
                end

                S_RING: begin
                    // A permitted snooze press takes priority over timeout.
                    if (w_snz_edge && (r_snz_used < c_max_snz)) begin
                        w_state_nxt = S_SNOOZE;
                        w_used_nxt  = r_snz_used + 2'd1;
                        w_tmr_nxt   = c_snz_load;
                    end else if (tick) begin
                        if (r_ring_cnt == c_ring_last) begin
                            w_state_nxt = S_DONE;
                        end else begin
                            w_ring_nxt = r_ring_cnt + 8'd1;
                        end
                    end
                end

                S_SNOOZE: begin
                    if (tick) begin
                        if (r_snz_tmr == 12'd1) begin
                            w_state_nxt = S_RING;
                            w_ring_nxt  = '0;
                            w_tmr_nxt   = '0;
                        end else if (r_snz_tmr != 12'd0) begin
                            w_tmr_nxt = r_snz_tmr - 12'd1;
                        end
                    end
                end

                S_DONE: begin
                    // Hold off re-triggering until the alarm minute has passed.
                    if (!w_match) begin
                        w_state_nxt = S_IDLE;
                        w_ring_nxt  = '0;
                        w_tmr_nxt   = '0;
                        w_used_nxt  = '0;
                    end
                end
            endcase
        end
    end

    assign buzz     = (r_state == S_RING);
    assign snoozing = (r_state == S_SNOOZE);
    assign snz_used = r_snz_used;

endmodule
`default_nettype wire

// File: doc/alarm_snooze_ctrl.md
ALARM_SNOOZE_CTRL -- requirements
Module: alarm_snooze_ctrl

Interface
REQ-001 Parameter SNOOZE_MIN, default 9, snooze length in minutes, legal 1..60.
REQ-002 Parameter RING_SEC, default 60, auto-silence timeout in seconds, legal 1..255.
REQ-003 Parameter MAX_SNOOZE, default 3, snoozes allowed per alarm event, legal 0..3.
REQ-004 clk  input  1  single system clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 tick  input  1  one-cycle strobe, once per second, aligned with the seconds counter advance.
REQ-007 tsec, tmin, thrs  input  7 each  current time in binary, from the time counters.
REQ-008 amin, ahrs  input  7 each  alarm setting in binary, from the alarm registers.
REQ-009 alarmon  input  1  alarm enable switch, level.
REQ-010 snooze  input  1  snooze button, level, synchronous to clk.
REQ-011 buzz  output  1  alarm sound request.
REQ-012 snoozing  output  1  high while a snooze interval is running.
REQ-013 snz_used  output  2  snoozes consumed in the current alarm event.

Function
REQ-014 Four-state FSM: IDLE, RING, SNOOZE, DONE; buzz = (state==RING), snoozing = (state==SNOOZE); both decode directly from the state register.
REQ-015 match = (tmin==amin) && (thrs==ahrs), full 7-bit compares.
REQ-016 IDLE -> RING on a cycle with alarmon && tick && tsec==0 && match; buzz rises the cycle after that edge; ring counter cleared to 0.
REQ-017 snz_edge = snooze && !snooze_q; snooze_q is a register of snooze.
REQ-018 RING: ring counter increments on each tick; when a tick arrives with counter == RING_SEC-1, go to DONE.
REQ-019 RING: snz_edge with snz_used < MAX_SNOOZE -> SNOOZE, snz_used += 1, snooze timer loaded with SNOOZE_MIN*60.
REQ-020 RING: snz_edge with snz_used == MAX_SNOOZE is ignored; state remains RING.
REQ-021 Same-cycle snz_edge (allowed per REQ-019) and ring timeout in RING: snooze wins.
REQ-022 SNOOZE: timer decrements on each tick; a tick with timer == 1 -> RING, ring counter cleared to 0; snz_edge is ignored.
REQ-023 DONE: remain until !match, then -> IDLE.
REQ-024 IDLE entry from any state clears snz_used, ring counter and snooze timer.
REQ-025 alarmon == 0 in any state forces IDLE on the next edge; this overrides every other transition.
REQ-026 Snooze timer is 12 bits (max 3600), unsigned; it never wraps below 0. Ring counter is 8 bits.
REQ-027 Time changes (setting, day wrap) during SNOOZE or RING do not alter state; only REQ-025 exits early.

Reset
REQ-028 On rst low, asynchronously: state=IDLE, buzz=0, snoozing=0, snz_used=0, ring counter=0, snooze timer=0, snooze_q=1.
REQ-029 snooze_q resetting to 1 means a button already held through reset release does not produce a snz_edge.
REQ-030 A reset asserted mid-RING or mid-SNOOZE abandons the event; the next trigger requires a fresh REQ-016 match.

Verification (bench parameters SNOOZE_MIN=1, RING_SEC=5, MAX_SNOOZE=2)
REQ-031 Setup: alarm 07:30, alarmon=1, tick at 07:30:00 -> buzz=1 next cycle; no snooze; after 5 ticks -> buzz=0, state DONE; at 07:31 -> IDLE.
REQ-032 Snooze pressed at ring second 2 -> buzz=0, snoozing=1, snz_used=1; after 60 ticks -> buzz=1 again with the ring counter restarted.
REQ-033 Third press after 2 snoozes -> ignored, buzz stays 1, snz_used=2; timeout -> DONE -> IDLE with snz_used=0.
REQ-034 snz_edge on the same cycle as the 5th ring tick -> SNOOZE, not DONE.
REQ-035 alarmon dropped during SNOOZE at timer=30 -> IDLE next edge, snoozing=0, snz_used=0; with alarmon=0 at 07:30:00 -> no buzz.
REQ-036 rst pulsed low mid-RING with snooze held through release -> all outputs 0 immediately; no snooze taken; tick at tsec=0 with match re-triggers buzz.
